// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: matrix row/column lines plus the key result outputs.
// The master side is the scanner itself; the slave side is the keypad/consumer.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner.
// Drives one column low at a time, synchronizes and debounces the rows, and
// emits one hex key code per physical press. Only one key is tracked at a
// time; everything else is ignored until that key is cleanly released.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 50000,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master kp
);

  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [3:0]    row_meta;
  logic [3:0]    row_s;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] deb_cnt;
  logic [1:0]    col_idx;
  logic [1:0]    cap_row;
  logic [3:0]    key_code_q;
  logic          key_valid_q;

  logic          row_hit;
  logic [1:0]    row_low_idx;
  logic          cap_low;
  logic          scan_last;
  logic          deb_last;

  // Row/column position to hex legend of the keypad.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous, pulled-up row lines.
  always_ff @(posedge clk) begin
    if (!reset) begin
      row_meta <= 4'b1111;
      row_s    <= 4'b1111;
    end else begin
      row_meta <= kp.row_n;
      row_s    <= row_meta;
    end
  end

  // Lowest-index low row wins when several rows are pressed in one column.
  always_comb begin
    row_low_idx = 2'd3;
    if (!row_s[0])      row_low_idx = 2'd0;
    else if (!row_s[1]) row_low_idx = 2'd1;
    else if (!row_s[2]) row_low_idx = 2'd2;
    else                row_low_idx = 2'd3;
  end

  assign row_hit   = (row_s != 4'b1111);
  assign cap_low   = ~row_s[cap_row];
  assign scan_last = (scan_cnt == SCAN_LAST);
  assign deb_last  = (deb_cnt == DEB_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= SCAN;
    else        state <= state_next;
  end

  // Next-state logic; only the captured row matters once a key is found.
  always_comb begin
    state_next = state;
    case (state)
      SCAN:     if (scan_last && row_hit) state_next = DEBOUNCE;
      DEBOUNCE: begin
        if (!cap_low)      state_next = SCAN;
        else if (deb_last) state_next = HELD;
      end
      HELD:     if (!cap_low) state_next = RELEASE;
      RELEASE:  begin
        if (cap_low)       state_next = HELD;
        else if (deb_last) state_next = SCAN;
      end
      default:  state_next = SCAN;
    endcase
  end

  // Counters, column position, captured row and the registered key outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt    <= '0;
      deb_cnt     <= '0;
      col_idx     <= 2'd0;
      cap_row     <= 2'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;

      if (state_next != state) begin
        scan_cnt <= '0;
        deb_cnt  <= '0;
      end else if (state == SCAN) begin
        scan_cnt <= scan_last ? '0 : scan_cnt + 1'b1;
      end else if (state == DEBOUNCE || state == RELEASE) begin
        deb_cnt <= deb_cnt + 1'b1;
      end

      if (state == SCAN && scan_last) begin
        if (row_hit) cap_row <= row_low_idx;
        else         col_idx <= col_idx + 2'd1;
      end

      if (state == RELEASE && !cap_low && deb_last) col_idx <= col_idx + 2'd1;

      if (state == DEBOUNCE && state_next == HELD) begin
        key_code_q  <= key_map(cap_row, col_idx);
        key_valid_q <= 1'b1;
      end
    end
  end

  // Output decode: one-hot active-low column drive and the held flag.
  always_comb begin
    kp.col_n     = ~(4'b0001 << col_idx);
    kp.key_held  = (state == HELD) || (state == RELEASE);
    kp.key_code  = key_code_q;
    kp.key_valid = key_valid_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a small keypad model and a
// scoreboard of expected key codes consumed on every key_valid pulse.
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic reset;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  logic [3:0] pressed [4];
  logic [3:0] row_model;
  logic [3:0] sb [$];
  logic [3:0] exp_code;
  logic       prev_valid = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  // Keypad model: a row reads low while a pressed key in it sits on a driven column.
  always_comb begin
    row_model = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !kp.col_n[c]) row_model[r] = 1'b0;
  end

  assign kp.row_n = row_model;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input int c, input logic down,
                               input logic expect_pulse, input logic [3:0] code);
    pressed[r][c] = down;
    if (expect_pulse) sb.push_back(code);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_held(input string tag, input logic level, input int bound, output int cycles);
    cycles = 0;
    while (kp.key_held !== level && cycles < bound) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput(tag, kp.key_held, level);
  endtask

  // Scoreboard consumer: every key_valid pulse must match the oldest expected code.
  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) begin
      checkOutput("valid_back_to_back", prev_valid, 1'b0);
      if (sb.size() == 0) begin
        checkOutput("spurious_valid", kp.key_valid, 1'b0);
      end else begin
        exp_code = sb.pop_front();
        checkOutput("pulse_key_code", kp.key_code, exp_code);
      end
    end
    prev_valid = kp.key_valid;
  end

  // Watchdog so a stuck design still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    logic [3:0] exp_col;
    logic [1:0] idx;
    logic [3:0] prev_col;

    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;

    // 1. Reset and idle scan rotation.
    reset = 1'b0;
    tick(3);
    checkOutput("rst_col_n", kp.col_n, 4'b1110);
    checkOutput("rst_key_code", kp.key_code, 4'h0);
    checkOutput("rst_key_valid", kp.key_valid, 1'b0);
    checkOutput("rst_key_held", kp.key_held, 1'b0);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      idx = 2'((k / 4) % 4);
      exp_col = 4'b1111 ^ (4'b0001 << idx);
      checkOutput("idle_scan_col", kp.col_n, exp_col);
    end

    // 2. Stable press of '5'. Release: 2 sync + 1 detect + 8 debounce = 11 cycles.
    applyStimulus(1, 1, 1'b1, 1'b1, 4'h5);
    tick(100);
    #1;
    checkOutput("t2_pulses_left", sb.size(), 0);
    checkOutput("t2_held", kp.key_held, 1'b1);
    checkOutput("t2_col_frozen", kp.col_n, 4'b1101);
    checkOutput("t2_code_hold", kp.key_code, 4'h5);
    applyStimulus(1, 1, 1'b0, 1'b0, 4'h0);
    wait_held("t2_release", 1'b0, 30, cyc);
    checkOutput("t2_release_latency", cyc, 11);
    checkOutput("t2_col_after", kp.col_n, 4'b1011);

    // 3. Bouncy '9', then stable.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2, 2, (i % 2 == 0), 1'b0, 4'h0);
      tick(3);
    end
    applyStimulus(2, 2, 1'b1, 1'b1, 4'h9);
    tick(50);
    #1;
    checkOutput("t3_pulses_left", sb.size(), 0);
    checkOutput("t3_held", kp.key_held, 1'b1);
    checkOutput("t3_code_hold", kp.key_code, 4'h9);
    applyStimulus(2, 2, 1'b0, 1'b0, 4'h0);
    wait_held("t3_release", 1'b0, 30, cyc);
    checkOutput("t3_release_latency", cyc, 11);
    checkOutput("t3_col_after", kp.col_n, 4'b0111);

    // 4. Release glitch on 'A'.
    applyStimulus(0, 3, 1'b1, 1'b1, 4'hA);
    wait_held("t4_accept", 1'b1, 60, cyc);
    #1;
    checkOutput("t4_pulses_left", sb.size(), 0);
    applyStimulus(0, 3, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t4_glitch_held", kp.key_held, 1'b1);
    end
    applyStimulus(0, 3, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("t4_repress_held", kp.key_held, 1'b1);
    end
    #1;
    applyStimulus(0, 3, 1'b0, 1'b0, 4'h0);
    wait_held("t4_release", 1'b0, 30, cyc);
    checkOutput("t4_release_latency", cyc, 11);
    checkOutput("t4_col_after", kp.col_n, 4'b1110);
    checkOutput("t4_code_hold", kp.key_code, 4'hA);

    // 5. Rollover: '2' held, '7' added, '2' released.
    applyStimulus(0, 1, 1'b1, 1'b1, 4'h2);
    wait_held("t5_accept_2", 1'b1, 60, cyc);
    #1;
    applyStimulus(2, 0, 1'b1, 1'b0, 4'h0);
    tick(30);
    #1;
    checkOutput("t5_pulses_left_2", sb.size(), 0);
    checkOutput("t5_code_2", kp.key_code, 4'h2);
    checkOutput("t5_col_frozen", kp.col_n, 4'b1101);
    applyStimulus(0, 1, 1'b0, 1'b1, 4'h7);
    wait_held("t5_release_2", 1'b0, 30, cyc);
    checkOutput("t5_release_latency", cyc, 11);
    wait_held("t5_accept_7", 1'b1, 60, cyc);
    #1;
    checkOutput("t5_pulses_left_7", sb.size(), 0);
    checkOutput("t5_code_7", kp.key_code, 4'h7);
    checkOutput("t5_col_7", kp.col_n, 4'b1110);
    applyStimulus(2, 0, 1'b0, 1'b0, 4'h0);
    wait_held("t5_release_7", 1'b0, 30, cyc);

    // 6. Reset at debounce count 5 of a '0' press.
    prev_col = kp.col_n;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (kp.col_n == 4'b1101 && prev_col != 4'b1101) break;
      prev_col = kp.col_n;
    end
    checkOutput("t6_col1_entry", kp.col_n, 4'b1101);
    applyStimulus(3, 1, 1'b1, 1'b0, 4'h0);
    tick(9);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_rst_col_n", kp.col_n, 4'b1110);
    checkOutput("t6_rst_key_code", kp.key_code, 4'h0);
    checkOutput("t6_rst_key_valid", kp.key_valid, 1'b0);
    checkOutput("t6_rst_key_held", kp.key_held, 1'b0);
    applyStimulus(3, 1, 1'b0, 1'b0, 4'h0);
    tick(2);
    reset = 1'b1;
    tick(20);
    #1;
    checkOutput("t6_no_hold", kp.key_held, 1'b0);
    checkOutput("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
